button_debounce_pulse: RTL
==========================

// Module: button_debounce_pulse
// PURPOSE
//   Conditions a raw, bouncy, asynchronous push-button input into a clean
//   debounced level and a single-cycle pulse per press.
//   Sits directly upstream of the 4-bit counter: pulse_out drives the
//   counter's enable input, so each press advances the count by exactly one.
//   An optional hold-to-repeat mode emits further pulses while the button is held.
// PARAMETERS
//   STABLE_CYCLES  16  clocks the synchronised input must hold steady to be accepted; legal >= 2
//   REPEAT_CYCLES  0   clocks between repeat pulses while held; 0 disables repeat; else >= 2
//   CNT_W          derived as $clog2(max(STABLE_CYCLES, REPEAT_CYCLES)+1); not user-set
// PORTS
//   clock      in   1  single system clock; all state updates on posedge
//   reset      in   1  asynchronous, active-low reset (0 = reset asserted)
//   button_in  in   1  raw button, asynchronous to clock, 1 = pressed
//   level_out  out  1  debounced button state
//   pulse_out  out  1  one-clock-wide pulse per accepted press or repeat
// BEHAVIOUR
//   Reset (reset=0, async, no clock needed):
//     - sync flops, counters and FSM all clear; state=IDLE.
//     - level_out=0, pulse_out=0; held until reset deasserts.
//   Synchroniser: button_in -> 2-flop chain -> sync. No other logic touches button_in.
//   Counters:
//     - stab_cnt (CNT_W) counts stable cycles; rep_cnt (CNT_W) counts repeat interval.
//     - Both saturate-free: always cleared before they could exceed their terminal value.
//   FSM, all transitions on posedge clock:
//     - IDLE: sync=1 -> PRESS_WAIT, stab_cnt=0.
//     - PRESS_WAIT:
//         sync=0 -> IDLE (press rejected, no pulse);
//         else stab_cnt==STABLE_CYCLES-1 -> HELD, level_out=1, pulse_out=1 for 1 cycle, rep_cnt=0;
//         else stab_cnt++.
//     - HELD:
//         sync=0 -> RELEASE_WAIT, stab_cnt=0;
//         else if REPEAT_CYCLES!=0 and rep_cnt==REPEAT_CYCLES-1 -> pulse_out=1 for 1 cycle, rep_cnt=0;
//         else rep_cnt++.
//     - RELEASE_WAIT:
//         sync=1 -> HELD, rep_cnt=0, no pulse;
//         else stab_cnt==STABLE_CYCLES-1 -> IDLE, level_out=0;
//         else stab_cnt++.
//   Latency: edge 0 = first posedge sampling button_in=1, input held steady.
//     - pulse_out and level_out rise after edge 2+STABLE_CYCLES.
//     - Release is symmetric: level_out falls after edge 2+STABLE_CYCLES.
//   Repeat: first repeat pulse comes REPEAT_CYCLES clocks after the initial pulse,
//     then every REPEAT_CYCLES clocks while held.
//   Boundary and ordering rules:
//     - pulse_out is never high on two consecutive cycles.
//     - pulse_out is never high while level_out=0.
//     - Release bounce never produces a pulse.
//     - Reset mid-operation aborts any wait; the next press is treated as new.
//   Outputs are registered; no combinational path from button_in to outputs.
// STRUCTURE
//   debounce_pkg:
//     - state_t enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}, 2-bit encoding.
//     - cnt_width() constant function.
//   Sub-module sync_2ff:
//     - 2-flop synchroniser, async active-low reset to 0.
//     - Reused for other asynchronous inputs.
//   Top: FSM + stab_cnt + rep_cnt + output registers.
// TESTING  (STABLE_CYCLES=4, REPEAT_CYCLES=8 unless noted)
//   1. Clean press: button_in=1 at edge 0, held 12 clks
//      -> pulse_out=1 only after edge 6; level_out=1 from edge 6.
//   2. Press bounce: toggle every 2 clks for 10 clks, then steady 1
//      -> exactly one pulse, 6 edges after the final rise; downstream count +1.
//   3. Glitch: button_in=1 for 3 clks, then 0 -> no pulse; level_out stays 0.
//   4. Hold with repeat: held 40 clks
//      -> pulses after edges 6, 14, 22, 30, 38; each one clock wide.
//   5. Release bounce: after HELD, 0/1/0 with 2-clk bounces, then steady 0
//      -> no extra pulse; level_out falls 6 edges after the final fall.
//   6. Reset mid PRESS_WAIT: reset=0 asynchronously between edges
//      -> outputs 0 immediately; after release, test 1 repeats exactly.
//      Also run with REPEAT_CYCLES=0: hold 40 clks -> single pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debounce/pulse block.
//   state_t     : debounce FSM state, 2-bit encoding
//   cnt_width() : width of the stable/repeat counters, sized so the larger
//                 of the two terminal values fits
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  function automatic int cnt_width(input int stable_cycles, input int repeat_cycles);
    int max_cycles;
    max_cycles = (stable_cycles > repeat_cycles) ? stable_cycles : repeat_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clock  : destination clock
//   reset  : asynchronous active-low reset, clears both flops to 0
//   d_in   : asynchronous input
//   q_out  : input synchronised to clock (two-cycle latency)
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounces a raw push-button and produces a one-clock pulse per accepted
// press, with optional hold-to-repeat pulses.
//   clock     : system clock, all state on posedge
//   reset     : asynchronous active-low reset
//   button_in : raw asynchronous button, 1 = pressed
//   level_out : debounced button state (registered)
//   pulse_out : one-clock pulse per accepted press or repeat (registered)
// Parameters:
//   STABLE_CYCLES : clocks the synchronised input must hold steady (>= 2)
//   REPEAT_CYCLES : clocks between repeat pulses while held; 0 disables (else >= 2)
module button_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic level_out,
  output logic pulse_out
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  // Guarded so a disabled repeat does not produce a negative terminal value.
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit               REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d_in  (button_in),
    .q_out (sync)
  );

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    level_d    = level_q;
    pulse_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d    = PRESS_WAIT;
          stab_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d   = HELD;
          level_d   = 1'b1;
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        // Release takes priority over a repeat pulse due on the same edge.
        if (!sync) begin
          state_d    = RELEASE_WAIT;
          stab_cnt_d = '0;
        end else if (REP_EN) begin
          if (rep_cnt_q == REP_LAST) begin
            pulse_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 returns to HELD silently; the repeat interval restarts.
        if (sync) begin
          state_d   = HELD;
          rep_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          stab_cnt_d = stab_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      stab_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;

endmodule
